// File: rtl/knight_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : knight_seq_if
// Description : Host-side control and lamp-output bundle for knight_seq.
// Revision    : 1.0 - initial release
// ============================================================================
interface knight_seq_if #(
    parameter int WIDTH = 8,
    parameter int DIVW  = 4
);
    logic             start;
    logic             stop;
    logic [1:0]       mode;
    logic [DIVW-1:0]  div;
    logic [3:0]       passes;
    logic [WIDTH-1:0] out;
    logic             busy;
    logic             done;

    modport master (
        output start, stop, mode, div, passes,
        input  out, busy, done
    );

    modport slave (
        input  start, stop, mode, div, passes,
        output out, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/knight_seq.sv
`default_nettype none
// ============================================================================
// Module      : knight_seq
// Description : Started, counted and stoppable knight-scanner lamp sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module knight_seq #(
    parameter int WIDTH = 8,
    parameter int DIVW  = 4
) (
    input  logic        ck,
    input  logic        res,
    knight_seq_if.slave bus
);
    localparam int PW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [PW-1:0] c_LAST_POS    = PW'(WIDTH - 1);
    localparam logic [1:0]    c_MODE_ROTL   = 2'd1;
    localparam logic [1:0]    c_MODE_ROTR   = 2'd2;
    localparam logic [1:0]    c_MODE_TRAIL  = 2'd3;
    localparam logic          c_DIR_LEFT    = 1'b0;
    localparam logic          c_DIR_RIGHT   = 1'b1;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t           state_q,  state_d;
    logic [1:0]       mode_q,   mode_d;
    logic [DIVW-1:0]  div_q,    div_d;
    logic [DIVW-1:0]  presc_q,  presc_d;
    logic [3:0]       passes_q, passes_d;
    logic [3:0]       pcnt_q,   pcnt_d;
    logic [PW-1:0]    pos_q,    pos_d;
    logic [PW-1:0]    prev_q,   prev_d;
    logic             dir_q,    dir_d;
    logic [WIDTH-1:0] out_q,    out_d;
    logic             busy_q,   busy_d;
    logic             done_q,   done_d;

    logic [PW-1:0]    nxt_pos;
    logic             nxt_dir;
    logic             pass_end;
    logic [3:0]       pcnt_inc;
    logic             run_end;

    function automatic logic [WIDTH-1:0] lamp(input logic [PW-1:0] p);
        lamp = {{(WIDTH-1){1'b0}}, 1'b1} << p;
    endfunction

    // Position/direction one step ahead, and whether that step closes a pass.
    always_comb begin
        nxt_pos  = pos_q;
        nxt_dir  = dir_q;
        pass_end = 1'b0;
        case (mode_q)
            c_MODE_ROTL: begin
                if (pos_q == c_LAST_POS) begin
                    nxt_pos  = '0;
                    pass_end = 1'b1;
                end else begin
                    nxt_pos = pos_q + 1'b1;
                end
            end
            c_MODE_ROTR: begin
                if (pos_q == '0) begin
                    nxt_pos = c_LAST_POS;
                end else begin
                    nxt_pos  = pos_q - 1'b1;
                    pass_end = (nxt_pos == '0);
                end
            end
            default: begin
                if (dir_q == c_DIR_LEFT) begin
                    nxt_pos = pos_q + 1'b1;
                    if (nxt_pos == c_LAST_POS) begin
                        nxt_dir = c_DIR_RIGHT;
                    end
                end else begin
                    nxt_pos = pos_q - 1'b1;
                    if (nxt_pos == '0) begin
                        nxt_dir  = c_DIR_LEFT;
                        pass_end = 1'b1;
                    end
                end
            end
        endcase
    end

    assign pcnt_inc = pcnt_q + 4'd1;
    assign run_end  = pass_end && (passes_q != 4'd0) && (pcnt_inc == passes_q);

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        div_d    = div_q;
        passes_d = passes_q;
        presc_d  = presc_q;
        pcnt_d   = pcnt_q;
        pos_d    = pos_q;
        prev_d   = prev_q;
        dir_d    = dir_q;
        out_d    = out_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                out_d  = '0;
                busy_d = 1'b0;
                if (bus.start && !bus.stop) begin
                    state_d  = S_RUN;
                    mode_d   = bus.mode;
                    div_d    = bus.div;
                    passes_d = bus.passes;
                    presc_d  = '0;
                    pcnt_d   = '0;
                    pos_d    = '0;
                    prev_d   = '0;
                    dir_d    = c_DIR_LEFT;
                    out_d    = lamp('0);
                    busy_d   = 1'b1;
                end
            end
            default: begin
                if (bus.stop) begin
                    state_d = S_IDLE;
                    out_d   = '0;
                    busy_d  = 1'b0;
                end else if (presc_q == div_q) begin
                    presc_d = '0;
                    pos_d   = nxt_pos;
                    prev_d  = pos_q;
                    dir_d   = nxt_dir;
                    if (pass_end) begin
                        pcnt_d = pcnt_inc;
                    end
                    if (run_end) begin
                        // The closing position-0 lamp is deliberately never shown.
                        state_d = S_IDLE;
                        out_d   = '0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        out_d = lamp(nxt_pos)
                              | ((mode_q == c_MODE_TRAIL) ? lamp(pos_q) : '0);
                    end
                end else begin
                    presc_d = presc_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge ck) begin
        if (res) begin
            state_q  <= S_IDLE;
            mode_q   <= '0;
            div_q    <= '0;
            passes_q <= '0;
            presc_q  <= '0;
            pcnt_q   <= '0;
            pos_q    <= '0;
            prev_q   <= '0;
            dir_q    <= c_DIR_LEFT;
            out_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            div_q    <= div_d;
            passes_q <= passes_d;
            presc_q  <= presc_d;
            pcnt_q   <= pcnt_d;
            pos_q    <= pos_d;
            prev_q   <= prev_d;
            dir_q    <= dir_d;
            out_q    <= out_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.out  = out_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
endmodule
`default_nettype wire

// File: doc/knight_seq.md
# knight_seq

Sequencer for the 8-lamp knight scanner display. It sits between host control (start/stop/mode) and the lamp output. It owns the step prescaler, the scan direction, the position register and the sweep-pass counter, and it drives the lamp vector directly. It replaces free-running scanning with a started, counted and stoppable run that reports completion.

## Interface
- WIDTH, 8, number of lamps (output width); all values below assume 8
- DIVW, 4, width of the step-divider input
- ck  in  1  clock, all state updates on rising edge
- res  in  1  synchronous reset, active-high
- start  in  1  level, sampled each edge; begins a run when idle
- stop  in  1  level, sampled each edge; aborts a run
- mode  in  2  scan mode: 0 bounce, 1 rotate left, 2 rotate right, 3 bounce with trail
- div  in  DIVW  step period minus one, in ck cycles
- passes  in  4  number of passes per run; 0 = unlimited
- out  out  WIDTH  lamp vector, one-hot (two adjacent bits in mode 3)
- busy  out  1  high while running
- done  out  1  one-cycle pulse on normal run completion

## Operation
- States: IDLE, RUN.
- IDLE: out=0, busy=0.
  - start=1 and stop=0 -> RUN.
  - Same edge: latch mode, div and passes; pos=0; dir=left; prescaler=0; pass count=0; out=0000_0001; busy=1.
- RUN: mode, div and passes inputs are ignored (latched copies used); start is ignored.
- Prescaler counts 0..div_latched. On the edge where it equals div_latched, a step occurs and the prescaler returns to 0. Step period = div+1 cycles; div=0 steps every cycle.
- Step, mode 0 (bounce): pos increments to 7, then decrements to 0.
  - Direction flips at 7 and at 0.
  - A pass completes on arrival at pos 0: 14 steps.
- Step, mode 1 (rotate left): pos+1, 7 wraps to 0. Pass completes on the 7->0 wrap: 8 steps.
- Step, mode 2 (rotate right): pos-1, 0 wraps to 7. Pass completes on return to 0: 8 steps.
- Step, mode 3: same motion as mode 0. out = lamp(pos) | lamp(prev_pos), where prev_pos = pos before the last step. prev_pos=pos at run start.
- Pass counter is 4-bit and increments on each completed pass.
  - passes_latched != 0: on the step completing pass number passes_latched -> IDLE, out=0, busy=0, done=1. The final position-0 lamp is not displayed.
  - passes_latched == 0: runs indefinitely; counter wraps freely and has no effect.
- stop=1 in RUN: next edge -> IDLE, out=0, busy=0, done stays 0. Stop has priority over a coinciding step or final-pass completion (no done).
- start=1 and stop=1 together in IDLE: stay IDLE.
- done is high for exactly one cycle, then 0. A start in the cycle done is high is accepted normally.

## Timing
- Reset (res=1 at an edge): state IDLE, out=0, busy=0, done=0, pos=0, dir=left, prescaler=0, pass count=0. Reset overrides start/stop and aborts a run mid-step without done.
- Start accepted at edge N: out=0000_0001 and busy=1 visible after edge N.
- k-th step lands at edge N + k*(div+1).
- Completion edge: N + steps_per_pass*passes*(div+1). After it, out=0, busy=0, done=1. done=0 after the next edge.
- Stop sampled at edge M: out=0, busy=0 after edge M.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Reset: hold res=1 for 2 edges with start=1 -> out=00, busy=0, done=0 throughout.
- Mode 1, div=0, passes=1, start pulse at edge 0:
  - out after edges 0..7 = 01,02,04,08,10,20,40,80.
  - Edge 8: out=00, busy=0, done=1. Edge 9: done=0.
- Mode 0, div=1, passes=1:
  - out changes every 2 cycles: 01..80 reached at edge 14, 40 at edge 16.
  - done at edge 28 with out=00.
- Mode 3, div=0, passes=0:
  - out = 01,03,06,0C,18,30,60,C0,C0,60,...
  - Run continues past 3 full sweeps. stop=1 at edge 50 -> out=00, busy=0, done never asserted.
- Mode 2, div=2, passes=2:
  - out = 01,80,40,... steps every 3 cycles.
  - done at edge 48. mode/div changes during the run have no effect.
- Boundary:
  - res=1 mid-run aborts with no done.
  - start+stop together in IDLE -> stays IDLE.
  - stop on the completing step -> no done.
  - start in the done cycle -> new run, out=01.
